// File: rtl/alu_cmd_issuer.sv
// Command FIFO, issue/capture FSM and response holding stage in front of a combinational ALU.
// Optional divide-by-zero trap: define ALU_DIV0_CHECK_EN.
package alu_cmd_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    SL  = 4'd4,
    SR  = 4'd5,
    AND = 4'd6,
    OR  = 4'd7,
    XOR = 4'd8
  } opcodes_t;
endpackage

module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int DATASIZE   = 8,
  parameter int OUTPUTSIZE = 2*DATASIZE,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  opcodes_t                     cmd_opcode,
  input  logic [DATASIZE-1:0]          cmd_in1,
  input  logic [DATASIZE-1:0]          cmd_in2,
  output opcodes_t                     alu_opcode,
  output logic [DATASIZE-1:0]          alu_in1,
  output logic [DATASIZE-1:0]          alu_in2,
  input  logic [OUTPUTSIZE-1:0]        alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [OUTPUTSIZE-1:0]        rsp_result,
  output opcodes_t                     rsp_opcode,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    opcodes_t            op;
    logic [DATASIZE-1:0] in1;
    logic [DATASIZE-1:0] in2;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  cmd_t                mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  state_t              state_q, state_d;
  opcodes_t            alu_opcode_q, alu_opcode_d, rsp_opcode_q, rsp_opcode_d;
  logic [DATASIZE-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [OUTPUTSIZE-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                push, pop, fifo_empty;
  cmd_t                head;

  // Returns {err, result} as it should be latched into the response stage.
`ifdef ALU_DIV0_CHECK_EN
  function automatic logic [OUTPUTSIZE:0] capture(input opcodes_t op,
                                                  input logic [DATASIZE-1:0] divisor,
                                                  input logic [OUTPUTSIZE-1:0] res);
    if (op == DIV && divisor == '0) return {1'b1, {OUTPUTSIZE{1'b1}}};
    return {1'b0, res};
  endfunction
`else
  function automatic logic [OUTPUTSIZE:0] capture(input logic [OUTPUTSIZE-1:0] res);
    return {1'b0, res};
  endfunction
`endif

  assign cmd_ready  = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_err_d    = rsp_err_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef ALU_DIV0_CHECK_EN
        {rsp_err_d, rsp_result_d} = capture(alu_opcode_q, alu_in2_q, alu_result);
`else
        {rsp_err_d, rsp_result_d} = capture(alu_result);
`endif
        rsp_opcode_d = alu_opcode_q;
        rsp_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          pop         = !fifo_empty;
          state_d     = fifo_empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ALU operand registers only move on a pop, so they stay quiet between commands.
    if (pop) begin
      alu_opcode_d = head.op;
      alu_in1_d    = head.in1;
      alu_in2_d    = head.in2;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= ADD;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= ADD;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_opcode, in1: cmd_in1, in2: cmd_in2};
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_err    = rsp_err_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: combinational ALU model, transaction-level scoreboard, directed and random traffic.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
  import alu_cmd_pkg::*;

  localparam int DATASIZE   = 8;
  localparam int OUTPUTSIZE = 16;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  opcodes_t         cmd_opcode, alu_opcode, rsp_opcode;
  logic [7:0]       cmd_in1, cmd_in2, alu_in1, alu_in2;
  logic [15:0]      alu_result, rsp_result;
  logic [CNT_W-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    opcodes_t   op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [16:0] got_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATASIZE(DATASIZE), .OUTPUTSIZE(OUTPUTSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .fifo_count(fifo_count)
  );

  function automatic logic [15:0] alu_fn(input opcodes_t op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x, y;
    x = 16'(a);
    y = 16'(b);
    case (op)
      ADD:     return x + y;
      SUB:     return x - y;
      MUL:     return x * y;
      DIV:     return (b == 8'd0) ? 16'd0 : x / y;
      SL:      return x << 1;
      SR:      return x >> 1;
      AND:     return x & y;
      OR:      return x | y;
      XOR:     return x ^ y;
      default: return 16'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_in1, alu_in2);

  function automatic logic [16:0] exp_rsp(input cmd_t c);
`ifdef ALU_DIV0_CHECK_EN
    if (c.op == DIV && c.b == 8'd0) return {1'b1, 16'hFFFF};
`endif
    return {1'b0, alu_fn(c.op, c.a, c.b)};
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endfunction

  // Compare process: scoreboard, stall stability and occupancy invariants, sampled on negedge.
  logic        stall_prev = 1'b0;
  logic [15:0] s_res;
  opcodes_t    s_op, s_aop;
  logic        s_err;
  logic [7:0]  s_a, s_b;
  logic [16:0] e_rsp;
  int          diff;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("cmd_ready_vs_full", 32'(cmd_ready), 32'(fifo_count != CNT_W'(DEPTH)));
      diff = exp_q.size() - int'(fifo_count);
      if (rsp_valid) chk("outstanding_hold", diff, 1);
      else chk("outstanding_other", 32'(diff == 0 || diff == 1), 1);
      if (stall_prev) begin
        chk("stall_valid", 32'(rsp_valid), 1);
        chk("stall_result", 32'(rsp_result), 32'(s_res));
        chk("stall_opcode", 32'(rsp_opcode), 32'(s_op));
        chk("stall_err", 32'(rsp_err), 32'(s_err));
        chk("stall_alu_op", 32'(alu_opcode), 32'(s_aop));
        chk("stall_alu_in1", 32'(alu_in1), 32'(s_a));
        chk("stall_alu_in2", 32'(alu_in2), 32'(s_b));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", exp_q.size(), 1);
        end else begin
          e_rsp = exp_rsp(exp_q[0]);
          chk("rsp_result", 32'(rsp_result), 32'(e_rsp[15:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e_rsp[16]));
          chk("rsp_opcode", 32'(rsp_opcode), 32'(exp_q[0].op));
          chk("alu_opcode", 32'(alu_opcode), 32'(exp_q[0].op));
          chk("alu_in1", 32'(alu_in1), 32'(exp_q[0].a));
          chk("alu_in2", 32'(alu_in2), 32'(exp_q[0].b));
          if (rsp_ready) begin
            got_q.push_back({rsp_err, rsp_result});
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      s_res = rsp_result; s_op = rsp_opcode; s_err = rsp_err;
      s_aop = alu_opcode; s_a = alu_in1; s_b = alu_in2;
      if (cmd_valid && cmd_ready) exp_q.push_back('{op: cmd_opcode, a: cmd_in1, b: cmd_in2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input opcodes_t op, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_in1 = a; cmd_in2 = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = cmd_ready;
      step();
    end
    if (!acc) chk("push_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (i < 200 && (exp_q.size() != 0 || rsp_valid)) begin
      step();
      i++;
    end
    chk("drain_done", exp_q.size() + int'(rsp_valid), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [24];
    int   f, n_acc;
    bit   acc;

    cmd_valid = 1'b0; cmd_opcode = ADD; cmd_in1 = 8'd0; cmd_in2 = 8'd0; rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_alu_in1", 32'(alu_in1), 0);
    chk("rst_alu_in2", 32'(alu_in2), 0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'(ADD));
    chk("rst_rsp_opcode", 32'(rsp_opcode), 32'(ADD));

    // Single ADD: latency from acceptance edge
    rsp_ready = 1'b1;
    push(ADD, 8'd200, 8'd100);
    chk("t1_valid_e0", 32'(rsp_valid), 0);
    step();
    chk("t1_valid_e1", 32'(rsp_valid), 0);
    step();
    chk("t1_valid_e2", 32'(rsp_valid), 1);
    chk("t1_result", 32'(rsp_result), 300);
    chk("t1_opcode", 32'(rsp_opcode), 32'(ADD));
    drain();

    // Four mixed ops under a long stall
    got_q.delete();
    rsp_ready = 1'b0;
    push(SUB, 8'd5, 8'd3);
    push(MUL, 8'd15, 8'd15);
    push(SL, 8'h81, 8'h00);
    push(XOR, 8'hF0, 8'h3C);
    chk("t2_fifo_count", 32'(fifo_count), 3);
    repeat (10) step();
    chk("t2_stalled_valid", 32'(rsp_valid), 1);
    chk("t2_stalled_result", 32'(rsp_result), 2);
    drain();
    chk("t2_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t2_r0", 32'(got_q[0][15:0]), 2);
      chk("t2_r1", 32'(got_q[1][15:0]), 225);
      chk("t2_r2", 32'(got_q[2][15:0]), 'h102);
      chk("t2_r3", 32'(got_q[3][15:0]), 'hCC);
    end

    // Fill to full, extra command must be refused
    got_q.delete();
    rsp_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) push(ADD, 8'(k), 8'd10);
    chk("t3_full_count", 32'(fifo_count), DEPTH);
    chk("t3_full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_opcode = XOR; cmd_in1 = 8'd1; cmd_in2 = 8'd1;
    repeat (3) begin
      step();
      chk("t3_ready_low", 32'(cmd_ready), 0);
      chk("t3_count_hold", 32'(fifo_count), DEPTH);
    end
    cmd_valid = 1'b0;
    drain();
    chk("t3_rsp_count", got_q.size(), DEPTH + 1);
    for (int k = 0; k <= DEPTH && k < got_q.size(); k++)
      chk("t3_rsp_value", 32'(got_q[k][15:0]), 10 + k);

    // Division, including divide by zero
    got_q.delete();
    push(DIV, 8'd9, 8'd0);
    push(DIV, 8'd9, 8'd2);
    drain();
    chk("t4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
`ifdef ALU_DIV0_CHECK_EN
      chk("t4_div0", 32'(got_q[0]), 'h1FFFF);
`else
      chk("t4_div0", 32'(got_q[0]), 0);
`endif
      chk("t4_div", 32'(got_q[1]), 4);
    end

    // Reset while holding a response with two queued
    got_q.delete();
    rsp_ready = 1'b0;
    push(ADD, 8'd1, 8'd1);
    push(ADD, 8'd2, 8'd2);
    push(ADD, 8'd3, 8'd3);
    chk("t5_hold_valid", 32'(rsp_valid), 1);
    chk("t5_hold_count", 32'(fifo_count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(rsp_valid), 0);
    chk("t5_rst_count", 32'(fifo_count), 0);
    rsp_ready = 1'b1;
    repeat (10) begin
      step();
      chk("t5_quiet", 32'(rsp_valid), 0);
    end
    chk("t5_no_rsp", got_q.size(), 0);

    // Back-to-back ANDs with rsp_ready high
    got_q.delete();
    rsp_ready = 1'b1;
    n_acc = 0;
    cmd_valid = 1'b1; cmd_opcode = AND;
    cmd_in1 = 8'($urandom); cmd_in2 = 8'($urandom);
    for (int i = 0; i < 24; i++) begin
      acc = cmd_ready;
      step();
      pat[i] = rsp_valid;
      if (acc) begin
        n_acc++;
        cmd_in1 = 8'($urandom); cmd_in2 = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    f = -1;
    for (int i = 0; i < 24; i++) if (f < 0 && pat[i]) f = i;
    chk("t6_first_valid", f, 2);
    if (f >= 0 && f <= 16)
      for (int j = 1; j < 8; j++) chk("t6_pattern", 32'(pat[f+j]), (j % 2 == 0) ? 1 : 0);
    drain();
    chk("t6_rsp_count", got_q.size(), n_acc);

    // Random traffic, including undefined opcodes and occasional reset
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom % 2) == 0;
      cmd_opcode = opcodes_t'(4'($urandom_range(0, 15)));
      cmd_in1    = 8'($urandom);
      cmd_in2    = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
      rsp_ready  = ($urandom % 3) != 0;
      rst        = ($urandom % 100) == 0;
      step();
    end
    rst = 1'b0;
    drain();
    chk("final_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
